// File: rtl/alu_ctrl_exec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_exec
//   Execute-stage ALU. Decodes alu_op/funct3/funct7_5 into an RV32I ALU
//   control code and performs the operation on XLEN-bit operands behind a
//   valid/ready handshake on both sides.
//
//   Build option: ALU_BARREL_SHIFT_EN
//     undefined (default) - shifts iterate one bit per cycle, latency shamt+1
//     defined             - shifts are combinational, latency always 1
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   operation offered          in_ready  block can accept
//     alu_op     00 add, 01 sub, 10 R-type, 11 I-type
//     funct3     instruction[14:12]         funct7_5  instruction[30]
//     src_a      operand A                  src_b     operand B / immediate
//     out_valid  result available           out_ready consumer takes result
//     result     operation result           zero      result == 0
//     alu_ctrl   decoded control code of the held operation
// ---------------------------------------------------------------------------
module alu_ctrl_exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              zero,
    output logic [3:0]        alu_ctrl
);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_SLL  = 4'b0010;
    localparam logic [3:0] C_SLT  = 4'b0011;
    localparam logic [3:0] C_SLTU = 4'b0100;
    localparam logic [3:0] C_XOR  = 4'b0101;
    localparam logic [3:0] C_SRL  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_OR   = 4'b1000;
    localparam logic [3:0] C_AND  = 4'b1001;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_r, state_n;
    logic [XLEN-1:0]      result_r;
    logic                 zero_r;
    logic [3:0]           ctrl_r;
    logic [XLEN-1:0]      work_r;
    logic [SHAMT_W-1:0]   cnt_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [3:0]           ctrl_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic                 start_shift_s;
    logic [XLEN-1:0]      alu_res_s;
    logic [XLEN-1:0]      step_s;

    // Map the 2+3+1 instruction bits onto a control code; every combination is defined.
    function automatic logic [3:0] decode_ctrl(input logic [1:0] op,
                                               input logic [2:0] f3,
                                               input logic       f7);
        logic [3:0] c;
        case (op)
            2'b00: c = C_ADD;
            2'b01: c = C_SUB;
            2'b10, 2'b11: begin
                case (f3)
                    3'b000:  c = ((op == 2'b10) && f7) ? C_SUB : C_ADD;
                    3'b001:  c = C_SLL;
                    3'b010:  c = C_SLT;
                    3'b011:  c = C_SLTU;
                    3'b100:  c = C_XOR;
                    3'b101:  c = f7 ? C_SRA : C_SRL;
                    3'b110:  c = C_OR;
                    3'b111:  c = C_AND;
                    default: c = C_ADD;
                endcase
            end
            default: c = C_ADD;
        endcase
        return c;
    endfunction

    // One-bit shift step of the iterative shifter; SRA replicates the sign bit.
    function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v,
                                                   input logic [3:0]      c);
        logic [XLEN-1:0] r;
        case (c)
            C_SLL:   r = {v[XLEN-2:0], 1'b0};
            C_SRL:   r = {1'b0, v[XLEN-1:1]};
            C_SRA:   r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign ctrl_s   = decode_ctrl(alu_op, funct3, funct7_5);
    assign shamt_s  = src_b[SHAMT_W-1:0];
    assign step_s   = shift_step(work_r, ctrl_r);

    // In DONE the slot frees up in the same cycle the consumer takes the result.
    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

`ifdef ALU_BARREL_SHIFT_EN
    assign start_shift_s = 1'b0;
`else
    logic is_shift_s;
    assign is_shift_s    = (ctrl_s == C_SLL) || (ctrl_s == C_SRL) || (ctrl_s == C_SRA);
    // A zero shift amount needs no iteration and completes like any other op.
    assign start_shift_s = is_shift_s && (shamt_s != CNT_ZERO);
`endif

    // Single-cycle result for the operation being accepted.
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (ctrl_s)
            C_ADD:  alu_res_s = src_a + src_b;
            C_SUB:  alu_res_s = src_a - src_b;
            C_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            C_XOR:  alu_res_s = src_a ^ src_b;
            C_OR:   alu_res_s = src_a | src_b;
            C_AND:  alu_res_s = src_a & src_b;
`ifdef ALU_BARREL_SHIFT_EN
            C_SLL:  alu_res_s = src_a << shamt_s;
            C_SRL:  alu_res_s = src_a >> shamt_s;
            C_SRA:  alu_res_s = $signed(src_a) >>> shamt_s;
`else
            // Only reached on this path with a zero shift amount.
            C_SLL, C_SRL, C_SRA: alu_res_s = src_a;
`endif
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic of the control FSM.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_n = start_shift_s ? ST_SHIFT : ST_DONE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_n = start_shift_s ? ST_SHIFT : ST_DONE;
                end else if (out_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, operand capture, shift iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            result_r <= {XLEN{1'b0}};
            zero_r   <= 1'b1;
            ctrl_r   <= C_ADD;
            work_r   <= {XLEN{1'b0}};
            cnt_r    <= CNT_ZERO;
        end else begin
            state_r <= state_n;
            if (accept_s) begin
                ctrl_r <= ctrl_s;
                if (start_shift_s) begin
                    work_r <= src_a;
                    cnt_r  <= shamt_s;
                end else begin
                    result_r <= alu_res_s;
                    zero_r   <= (alu_res_s == {XLEN{1'b0}});
                end
            end else if (state_r == ST_SHIFT) begin
                work_r <= step_s;
                cnt_r  <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_r <= step_s;
                    zero_r   <= (step_s == {XLEN{1'b0}});
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign zero      = zero_r;
    assign alu_ctrl  = ctrl_r;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_exec
//   Directed-vector bench for alu_ctrl_exec (XLEN=32). Expected values are
//   hand-computed; shift latency expectations follow ALU_BARREL_SHIFT_EN.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_ctrl;

    int vec_cnt;
    int err_cnt;

    alu_ctrl_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .alu_ctrl  (alu_ctrl)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift latency in cycles from accept to out_valid for a given shamt.
    function automatic int shift_lat(input int shamt);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (shamt == 0) ? 1 : shamt + 1;
`endif
    endfunction

    // Issue one op from idle, wait for the result, check it, then retire it.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [3:0] exp_ctrl,
                          input int exp_lat);
        int lat;
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        alu_op = op; funct3 = f3; funct7_5 = f7; src_a = a; src_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble operands: they must not matter after accept.
        alu_op = 2'b01; funct3 = 3'b110; funct7_5 = ~f7;
        src_a = 32'hDEADBEEF; src_b = 32'h0000001F;
        if (exp_lat > 1) begin
            check_val({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_result"}, result, exp_res);
        check_val({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, exp_ctrl});
        check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_retired"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0;
        src_a = 32'd0; src_b = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_zero", {31'd0, zero}, 32'd1);
        check_val("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Test-plan cases 1, 2, 3.
        run_op("c1_sub", 2'b10, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 1);
        run_op("c2_iadd", 2'b11, 3'b000, 1'b1, 32'd3, 32'd4, 32'd7, 4'b0000, 1);
        run_op("c3_sra", 2'b10, 3'b101, 1'b1, 32'h80000000, 32'h24, 32'hF8000000, 4'b0111,
               shift_lat(4));

        // Additional directed vectors.
        run_op("add_wrap", 2'b00, 3'b111, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0000, 1);
        run_op("br_sub", 2'b01, 3'b000, 1'b0, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b0001, 1);
        run_op("xor", 2'b10, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0101, 1);
        run_op("or", 2'b10, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 4'b1000, 1);
        run_op("and", 2'b11, 3'b111, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1001, 1);
        run_op("srl", 2'b11, 3'b101, 1'b0, 32'h80000000, 32'h23, 32'h10000000, 4'b0110,
               shift_lat(3));
        run_op("sll0", 2'b11, 3'b001, 1'b0, 32'h3, 32'h20, 32'h3, 4'b0010, shift_lat(0));
        run_op("sra1", 2'b10, 3'b101, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h3FFFFFFF, 4'b0111,
               shift_lat(1));
        run_op("sll4", 2'b10, 3'b001, 1'b0, 32'h0000000F, 32'h4, 32'h000000F0, 4'b0010,
               shift_lat(4));

        // Case 5: signed vs unsigned compare.
        run_op("c5_slt", 2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0011, 1);
        run_op("c5_sltu", 2'b10, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100, 1);

        // Case 4: backpressure hold, then back-to-back accept.
        alu_op = 2'b01; funct3 = 3'b000; funct7_5 = 1'b0;
        src_a = 32'h1234; src_b = 32'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        src_a = 32'h5555; src_b = 32'h1;
        check_val("c4_valid", {31'd0, out_valid}, 32'd1);
        check_val("c4_result", result, 32'd0);
        check_val("c4_zero", {31'd0, zero}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("c4_hold_valid", {31'd0, out_valid}, 32'd1);
            check_val("c4_hold_result", result, 32'd0);
            check_val("c4_hold_ctrl", {28'd0, alu_ctrl}, 32'd1);
            check_val("c4_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        alu_op = 2'b10; funct3 = 3'b011; funct7_5 = 1'b0;
        src_a = 32'd1; src_b = 32'hFFFFFFFF;
        in_valid = 1'b1;
        #1;
        check_val("c4_b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("c4_b2b_valid", {31'd0, out_valid}, 32'd1);
        check_val("c4_b2b_result", result, 32'd1);
        check_val("c4_b2b_ctrl", {28'd0, alu_ctrl}, 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("c4_retired", {31'd0, out_valid}, 32'd0);

        // Case 6: reset during a long shift.
        alu_op = 2'b10; funct3 = 3'b001; funct7_5 = 1'b0;
        src_a = 32'd1; src_b = 32'd31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
`ifndef ALU_BARREL_SHIFT_EN
        check_val("c6_mid_valid", {31'd0, out_valid}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("c6_rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("c6_rst_result", result, 32'd0);
        check_val("c6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        // A few idle cycles: the aborted shift must not resurface.
        tick();
        tick();
        check_val("c6_idle_valid", {31'd0, out_valid}, 32'd0);
        run_op("c6_add", 2'b00, 3'b000, 1'b0, 32'd2, 32'd2, 32'd4, 4'b0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
